// File: rtl/stage_event_sequencer.sv
// Walks a stage's records in a synchronous ROM and releases each SPAWN record as a
// valid/ready event once the stage clock reaches the record's trigger time.
module stage_event_sequencer #(
    parameter int REC_W  = 72,
    parameter int ADDR_W = 10,
    parameter int TIME_W = 30,
    parameter int IDX_W  = 20
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [TIME_W-1:0] current_time,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [REC_W-1:0]  rom_data,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [31:0]       ev_payload,
    output logic [IDX_W-1:0]  ev_index,
    output logic              busy,
    output logic              stage_done,
    output logic              overflow
);

    localparam logic [7:0] TAG_SPAWN = 8'h00;
    localparam logic [7:0] TAG_END   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WAIT_TIME,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic                ev_valid_q;
    logic [31:0]         ev_payload_q;
    logic [IDX_W-1:0]    ev_index_q;
    logic                busy_q;
    logic                stage_done_q;
    logic                overflow_q;
    logic [TIME_W-1:0]   rec_time_q;
    logic [31:0]         rec_payload_q;

    logic [7:0]          rec_tag;
    logic                addr_last;
    logic                unused_rec_bits;

    assign rec_tag         = rom_data[71:64];
    assign addr_last       = &rom_addr_q;
    assign unused_rec_bits = ^rom_data[31:TIME_W];

    // Record register: captured while the ROM word is presented in CHECK.
    always_ff @(posedge clk) begin
        if (state_q == S_CHECK) begin
            rec_time_q    <= rom_data[TIME_W-1:0];
            rec_payload_q <= rom_data[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= '0;
            ev_valid_q   <= 1'b0;
            ev_payload_q <= '0;
            ev_index_q   <= '0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else if (abort) begin
            state_q      <= S_IDLE;
            ev_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            stage_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        rom_addr_q   <= base_addr;
                        ev_index_q   <= '0;
                        overflow_q   <= 1'b0;
                        stage_done_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (rec_tag == TAG_END) begin
                        busy_q       <= 1'b0;
                        stage_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (rec_tag == TAG_SPAWN) begin
                        state_q <= S_WAIT_TIME;
                    end else if (addr_last) begin
                        overflow_q   <= 1'b1;
                        busy_q       <= 1'b0;
                        stage_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                        state_q    <= S_READ;
                    end
                end
                S_WAIT_TIME: begin
                    if (current_time >= rec_time_q) begin
                        ev_payload_q <= rec_payload_q;
                        ev_valid_q   <= 1'b1;
                        state_q      <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    // Payload stays frozen after the handshake; only ev_valid drops.
                    if (ev_ready) begin
                        ev_valid_q <= 1'b0;
                        if (!(&ev_index_q)) begin
                            ev_index_q <= ev_index_q + IDX_W'(1);
                        end
                        if (addr_last) begin
                            overflow_q   <= 1'b1;
                            busy_q       <= 1'b0;
                            stage_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            rom_addr_q <= rom_addr_q + ADDR_W'(1);
                            state_q    <= S_READ;
                        end
                    end
                end
                default: begin
                    busy_q       <= 1'b0;
                    stage_done_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = rom_addr_q;
    assign ev_valid   = ev_valid_q;
    assign ev_payload = ev_payload_q;
    assign ev_index   = ev_index_q;
    assign busy       = busy_q;
    assign stage_done = stage_done_q;
    assign overflow   = overflow_q;

`ifndef SYNTHESIS
    // An offered event may only be withdrawn by a handshake, abort or reset.
    a_ev_hold: assert property (@(posedge clk) disable iff (!sync_reset)
        (ev_valid_q && !ev_ready && !abort) |=> (ev_valid_q && $stable(ev_payload_q)));

    a_status: assert property (@(posedge clk) disable iff (!sync_reset)
        (busy_q == !(state_q == S_IDLE || state_q == S_DONE)) &&
        (stage_done_q == (state_q == S_DONE)));
`endif

endmodule

// File: tb/tb_stage_event_sequencer.sv
// Scoreboard bench: a record-walking model queues expected events, a negedge monitor
// pops and compares them at every handshake.
module tb_stage_event_sequencer;

    logic        clk = 1'b0;
    logic        sync_reset;
    logic        start;
    logic        abort;
    logic [9:0]  base_addr;
    logic [29:0] current_time;
    logic [9:0]  rom_addr;
    logic [71:0] rom_data;
    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] ev_payload;
    logic [19:0] ev_index;
    logic        busy;
    logic        stage_done;
    logic        overflow;

    logic [71:0] mem [1024];

    typedef struct {
        logic [31:0] payload;
        logic [19:0] idx;
        logic [29:0] t;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    stage_event_sequencer #(
        .REC_W(72), .ADDR_W(10), .TIME_W(30), .IDX_W(20)
    ) dut (
        .clk(clk), .sync_reset(sync_reset), .start(start), .abort(abort),
        .base_addr(base_addr), .current_time(current_time),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_payload(ev_payload),
        .ev_index(ev_index), .busy(busy), .stage_done(stage_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] rec(input logic [7:0] tag, input logic [31:0] p,
                                        input logic [29:0] t);
        return {tag, p, 2'b00, t};
    endfunction

    // Reference walk of a stage: every SPAWN becomes an event, END stops, others skip.
    task automatic model_stage(input int base, output bit ovf, output int n_ev);
        int a = base;
        bit fin = 0;
        logic [71:0] r;
        exp_t e;
        ovf  = 0;
        n_ev = 0;
        while (!fin) begin
            r = mem[a];
            if (r[71:64] == 8'hFF) begin
                fin = 1;
            end else begin
                if (r[71:64] == 8'h00) begin
                    e.payload = r[63:32];
                    e.idx     = 20'(n_ev);
                    e.t       = r[29:0];
                    sb.push_back(e);
                    n_ev++;
                end
                if (a == 1023) begin
                    ovf = 1;
                    fin = 1;
                end else begin
                    a++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sync_reset && !abort && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: payload %0h index %0d, no event expected",
                         ev_payload, ev_index);
            end else begin
                e = sb.pop_front();
                check("ev_payload", 64'(ev_payload), 64'(e.payload));
                check("ev_index", 64'(ev_index), 64'(e.idx));
                check("ev_time_reached", 64'(current_time >= e.t), 64'(1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_stage(input int base);
        base_addr = 10'(base);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input bit ct_run);
        int n = 0;
        while (!stage_done && n < budget) begin
            if (rnd) ev_ready = 1'($urandom_range(0, 1));
            if (ct_run) current_time = current_time + 30'd1;
            tick();
            n++;
        end
        check("stage_done_within_budget", 64'(stage_done), 64'(1));
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!ev_valid && n < budget) begin
            tick();
            n++;
        end
        check("ev_valid_within_budget", 64'(ev_valid), 64'(1));
    endtask

    initial begin
        bit ovf;
        int nev;
        int first_valid;
        int first_done;
        int first_ct;
        int changes;
        int n;
        logic [31:0] held;

        for (int i = 0; i < 1024; i++) mem[i] = rec(8'hFF, 32'h0, 30'h0);
        sync_reset   = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        base_addr    = '0;
        current_time = '0;
        ev_ready     = 1'b0;
        repeat (3) tick();

        check("rst_rom_addr", 64'(rom_addr), 64'(0));
        check("rst_ev_valid", 64'(ev_valid), 64'(0));
        check("rst_ev_payload", 64'(ev_payload), 64'(0));
        check("rst_ev_index", 64'(ev_index), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_stage_done", 64'(stage_done), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        sync_reset = 1'b1;
        tick();

        // Latency of a single immediate event and of the following END.
        mem[0] = rec(8'h00, 32'hA1, 30'd0);
        mem[1] = rec(8'hFF, 32'h0, 30'd0);
        model_stage(0, ovf, nev);
        ev_ready    = 1'b1;
        first_valid = -1;
        first_done  = -1;
        start_stage(0);
        for (int c = 0; c < 12; c++) begin
            if (ev_valid && first_valid < 0) first_valid = c;
            if (stage_done && first_done < 0) first_done = c;
            tick();
        end
        check("t1_first_valid_cycle", 64'(first_valid), 64'(3));
        check("t1_stage_done_cycle", 64'(first_done), 64'(6));
        check("t1_busy_after_done", 64'(busy), 64'(0));
        check("t1_scoreboard_empty", 64'(sb.size()), 64'(0));

        // Trigger time gates the event.
        mem[10] = rec(8'h00, 32'h5050, 30'd50);
        model_stage(10, ovf, nev);
        current_time = '0;
        first_ct = -1;
        start_stage(10);
        for (int v = 0; v <= 100; v++) begin
            current_time = 30'(v);
            for (int c = 0; c < 10; c++) begin
                if (ev_valid && first_ct < 0) first_ct = int'(current_time);
                tick();
            end
        end
        check("t2_first_valid_time", 64'(first_ct), 64'(50));
        check("t2_stage_done", 64'(stage_done), 64'(1));
        check("t2_scoreboard_empty", 64'(sb.size()), 64'(0));

        // Back-pressure holds the offer stable.
        mem[20] = rec(8'h00, 32'hC3, 30'd0);
        mem[21] = rec(8'h00, 32'hC4, 30'd0);
        current_time = 30'd5;
        ev_ready = 1'b0;
        model_stage(20, ovf, nev);
        start_stage(20);
        wait_valid(20);
        held = ev_payload;
        changes = 0;
        for (int c = 0; c < 20; c++) begin
            if (!ev_valid || ev_payload !== held) changes++;
            tick();
        end
        check("t3_offer_stable", 64'(changes), 64'(0));
        ev_ready = 1'b1;
        tick();
        check("t3_valid_dropped", 64'(ev_valid), 64'(0));
        check("t3_index_after_first", 64'(ev_index), 64'(1));
        wait_done(60, 0, 0);
        check("t3_index_final", 64'(ev_index), 64'(nev));
        check("t3_scoreboard_empty", 64'(sb.size()), 64'(0));

        // SKIP record ahead of a SPAWN.
        mem[30] = rec(8'h07, 32'hDEAD, 30'd0);
        mem[31] = rec(8'h00, 32'hB2, 30'd0);
        model_stage(30, ovf, nev);
        start_stage(30);
        wait_done(60, 0, 0);
        check("t4_index_final", 64'(ev_index), 64'(1));
        check("t4_scoreboard_empty", 64'(sb.size()), 64'(0));

        // Last address without END.
        mem[1023] = rec(8'h00, 32'hD5, 30'd0);
        model_stage(1023, ovf, nev);
        start_stage(1023);
        wait_done(60, 0, 0);
        check("t5_overflow", 64'(overflow), 64'(ovf));
        check("t5_overflow_set", 64'(overflow), 64'(1));
        check("t5_index_final", 64'(ev_index), 64'(1));
        check("t5_scoreboard_empty", 64'(sb.size()), 64'(0));

        // Randomised stages with skips, trigger times and back-pressure.
        for (int r = 0; r < 5; r++) begin
            int base = 100 + r * 60;
            int cnt = int'($urandom_range(3, 12));
            for (int k = 0; k < cnt; k++) begin
                int sel = int'($urandom_range(0, 9));
                logic [7:0] tg;
                tg = (sel < 7) ? 8'h00 : 8'($urandom_range(1, 254));
                mem[base + k] = rec(tg, $urandom, 30'($urandom_range(0, 150)));
            end
            mem[base + cnt] = rec(8'hFF, 32'h0, 30'd0);
            current_time = '0;
            model_stage(base, ovf, nev);
            start_stage(base);
            wait_done(2000, 1, 1);
            check("rnd_overflow", 64'(overflow), 64'(ovf));
            check("rnd_index_final", 64'(ev_index), 64'(nev));
            check("rnd_scoreboard_empty", 64'(sb.size()), 64'(0));
        end

        // Abort while an event is offered, then reset.
        mem[40] = rec(8'h00, 32'hE6, 30'd0);
        mem[41] = rec(8'h00, 32'hE7, 30'd0);
        mem[42] = rec(8'hFF, 32'h0, 30'd0);
        current_time = '0;
        ev_ready = 1'b1;
        model_stage(40, ovf, nev);
        start_stage(40);
        n = 0;
        while (ev_index != 20'd1 && n < 40) begin
            tick();
            n++;
        end
        check("t6_first_transfer", 64'(ev_index), 64'(1));
        ev_ready = 1'b0;
        wait_valid(20);
        abort     = 1'b1;
        start     = 1'b1;
        base_addr = 10'd500;
        tick();
        abort = 1'b0;
        start = 1'b0;
        sb.delete();
        check("t6_abort_valid", 64'(ev_valid), 64'(0));
        check("t6_abort_busy", 64'(busy), 64'(0));
        check("t6_abort_done", 64'(stage_done), 64'(0));
        check("t6_abort_addr_hold", 64'(rom_addr), 64'(41));
        check("t6_abort_index_hold", 64'(ev_index), 64'(1));
        tick();
        check("t6_start_ignored", 64'(busy), 64'(0));
        sync_reset = 1'b0;
        tick();
        check("t6_rst_rom_addr", 64'(rom_addr), 64'(0));
        check("t6_rst_ev_valid", 64'(ev_valid), 64'(0));
        check("t6_rst_ev_payload", 64'(ev_payload), 64'(0));
        check("t6_rst_ev_index", 64'(ev_index), 64'(0));
        check("t6_rst_busy", 64'(busy), 64'(0));
        check("t6_rst_stage_done", 64'(stage_done), 64'(0));
        check("t6_rst_overflow", 64'(overflow), 64'(0));
        sync_reset = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
